// File: rtl/finite_log.sv
// Discrete logarithm over GF(2^M), standard basis: steps a running power of
// alpha, STEPS candidates per cycle, until it equals the requested element.
module finite_log #(
  parameter int M     = 4,
  parameter int STEPS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] standard_in,
  output logic         busy,
  output logic         valid,
  output logic         zero,
  output logic [M-1:0] log_out
);

  // Low M coefficients of the primitive BCH field polynomial for degree m.
  function automatic logic [M-1:0] bch_taps(input int m);
    logic [15:0] t;
    case (m)
      2:       t = 16'h0003;
      3:       t = 16'h0003;
      4:       t = 16'h0003;
      5:       t = 16'h0005;
      6:       t = 16'h0003;
      7:       t = 16'h0003;
      8:       t = 16'h001D;
      9:       t = 16'h0011;
      10:      t = 16'h0009;
      11:      t = 16'h0005;
      12:      t = 16'h0053;
      13:      t = 16'h001B;
      14:      t = 16'h0443;
      15:      t = 16'h0003;
      16:      t = 16'h100B;
      default: t = 16'h0000;
    endcase
    return t[M-1:0];
  endfunction

  localparam logic [M-1:0] TAPS     = bch_taps(M);
  localparam logic [M:0]   LAST_EXP = (M+1)'((1 << M) - 1);

  // Constant multiplication by alpha: shift, then reduce by the field polynomial.
  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? TAPS : '0);
  endfunction

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t       state;
  logic [M-1:0] target;
  logic [M-1:0] cur;
  logic [M-1:0] exp;

  logic         hit;
  logic [M-1:0] hit_j;
  logic [M-1:0] cur_next;
  logic         exhausted;

  // Candidate chain cur*alpha^j; the first match wins, the chain tail is the next cur.
  always_comb begin
    logic [M-1:0] c;
    hit   = 1'b0;
    hit_j = '0;
    c     = cur;
    for (int j = 0; j < STEPS; j++) begin
      if (!hit && c == target) begin
        hit   = 1'b1;
        hit_j = M'(j);
      end
      c = mul_alpha(c);
    end
    cur_next = c;
  end

  assign exhausted = ({1'b0, exp} + (M+1)'(STEPS)) >= LAST_EXP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      zero    <= 1'b0;
      log_out <= '0;
      target  <= '0;
      cur     <= M'(1);
      exp     <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (standard_in != '0) begin
              target <= standard_in;
              cur    <= M'(1);
              exp    <= '0;
              busy   <= 1'b1;
              state  <= SEARCH;
            end else begin
              valid   <= 1'b1;
              zero    <= 1'b1;
              log_out <= '0;
            end
          end
        end
        SEARCH: begin
          if (hit) begin
            log_out <= exp + hit_j;
            zero    <= 1'b0;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (exhausted) begin
            // Only reachable with a non-primitive polynomial.
            log_out <= '0;
            zero    <= 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cur <= cur_next;
            exp <= exp + M'(STEPS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_exhaust: assert property (@(posedge clk) disable iff (reset)
    !(state == SEARCH && !hit && exhausted));

endmodule
